// File: rtl/unit_pkt_serializer.sv
// Serialises one packet descriptor into the byte stream of a sha512unit; data packets go to one unit
// (round-robin), init packets to all. Optional statistics ports are enabled by UNIT_PKT_STATS_EN.
module unit_pkt_serializer #(
    parameter int N_UNITS     = 4,
    parameter int KEY_MAX_LEN = 64,
    parameter int GAP_CYCLES  = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     desc_valid,
    output logic                     desc_ready,
    input  logic                     desc_init,
    input  logic [4:0]               desc_init_data,
    input  logic [31:0]              desc_cnt,
    input  logic [7:0]               desc_salt_len,
    input  logic [127:0]             desc_salt,
    input  logic [63:0]              desc_ids,
    input  logic [7:0]               desc_key_len,
    input  logic [KEY_MAX_LEN*8-1:0] desc_key,
    output logic [8*N_UNITS-1:0]     unit_in,
    output logic [N_UNITS-1:0]       unit_in_ctrl,
    output logic [N_UNITS-1:0]       unit_in_wr_en,
    input  logic [N_UNITS-1:0]       unit_in_afull,
    input  logic [N_UNITS-1:0]       unit_in_ready,
    output logic                     len_err
`ifdef UNIT_PKT_STATS_EN
    ,
    output logic [31:0]              pkt_count,
    output logic [31:0]              stall_count
`endif
);

    localparam int UW = (N_UNITS > 1) ? $clog2(N_UNITS) : 1;
    localparam int KW = (KEY_MAX_LEN > 1) ? $clog2(KEY_MAX_LEN) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_SELECT, S_HDR, S_BODY, S_TRAILER, S_GAP, S_INIT
    } state_t;

    state_t          state_q, state_d;
    logic [UW-1:0]   rr_q, rr_d;
    logic [UW-1:0]   sel_q, sel_d;
    logic [6:0]      byte_q, byte_d;
    logic [7:0]      gap_q, gap_d;
    logic            desc_ready_q, desc_ready_d;
    logic            len_err_q, len_err_d;

    logic [31:0]     cnt_q;
    logic [7:0]      salt_len_q;
    logic [7:0]      salt_q [16];
    logic [63:0]     ids_q;
    logic [7:0]      key_len_q;
    logic [7:0]      key_q [KEY_MAX_LEN];
    logic [4:0]      init_data_q;

    logic [7:0]      salt_b [16];
    logic [7:0]      key_b [KEY_MAX_LEN];
    logic            accept, salt_clamp, key_clamp;
    logic            emit, emit_all, emit_ctrl, clear;
    logic [7:0]      emit_byte, body_byte;
    logic [6:0]      salt_off, key_off, body_last;
    logic [7:0]      key_ceil4;
    logic            afull_sel;
    logic            found;
    logic [UW-1:0]   cand;

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_salt_b
            assign salt_b[gi] = desc_salt[gi*8 +: 8];
        end
        for (genvar gi = 0; gi < KEY_MAX_LEN; gi++) begin : g_key_b
            assign key_b[gi] = desc_key[gi*8 +: 8];
        end
    endgenerate

    assign salt_clamp = (desc_salt_len > 8'd16);
    assign key_clamp  = (desc_key_len > 8'(KEY_MAX_LEN));
    assign afull_sel  = unit_in_afull[sel_q];
    assign key_ceil4  = (key_len_q + 8'd3) & 8'hFC;
    // Body = 40 fixed bytes followed by the key padded to a 4-byte multiple.
    assign body_last  = 7'd39 + key_ceil4[6:0];

    always_ff @(posedge CLK) begin
        if (accept) begin
            cnt_q       <= desc_cnt;
            salt_len_q  <= salt_clamp ? 8'd16 : desc_salt_len;
            salt_q      <= salt_b;
            ids_q       <= desc_ids;
            key_len_q   <= key_clamp ? 8'(KEY_MAX_LEN) : desc_key_len;
            key_q       <= key_b;
            init_data_q <= desc_init_data;
        end
    end

    always_comb begin
        salt_off  = byte_q - 7'd8;
        key_off   = byte_q - 7'd40;
        body_byte = 8'h00;
        if (byte_q < 7'd4) begin
            body_byte = cnt_q[{byte_q[1:0], 3'b000} +: 8];
        end else if (byte_q == 7'd4) begin
            body_byte = salt_len_q;
        end else if (byte_q >= 7'd8 && byte_q < 7'd24) begin
            if ({1'b0, salt_off} < salt_len_q) body_byte = salt_q[salt_off[3:0]];
        end else if (byte_q >= 7'd24 && byte_q < 7'd32) begin
            body_byte = ids_q[{byte_q[2:0], 3'b000} +: 8];
        end else if (byte_q == 7'd32) begin
            body_byte = key_len_q;
        end else if (byte_q >= 7'd40) begin
            if ({1'b0, key_off} < key_len_q) body_byte = key_q[key_off[KW-1:0]];
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        sel_d        = sel_q;
        byte_d       = byte_q;
        gap_d        = gap_q;
        desc_ready_d = 1'b0;
        len_err_d    = 1'b0;
        accept       = 1'b0;
        emit         = 1'b0;
        emit_all     = 1'b0;
        emit_ctrl    = 1'b0;
        emit_byte    = 8'h00;
        clear        = 1'b0;
        found        = 1'b0;
        cand         = '0;
        case (state_q)
            S_IDLE: begin
                clear        = 1'b1;
                desc_ready_d = 1'b1;
                if (desc_valid && desc_ready_q) begin
                    accept       = 1'b1;
                    desc_ready_d = 1'b0;
                    len_err_d    = salt_clamp || key_clamp;
                    state_d      = desc_init ? S_INIT : S_SELECT;
                end
            end
            S_SELECT: begin
                clear = 1'b1;
                for (int i = 0; i < N_UNITS; i++) begin
                    cand = UW'((int'(rr_q) + 1 + i) % N_UNITS);
                    if (!found && unit_in_ready[cand]) begin
                        found   = 1'b1;
                        sel_d   = cand;
                        rr_d    = cand;
                        byte_d  = '0;
                        state_d = S_HDR;
                    end
                end
            end
            S_HDR: begin
                if (!afull_sel) begin
                    emit      = 1'b1;
                    emit_ctrl = 1'b1;
                    state_d   = S_BODY;
                end
            end
            S_BODY: begin
                if (!afull_sel) begin
                    emit      = 1'b1;
                    emit_byte = body_byte;
                    if (byte_q == body_last) state_d = S_TRAILER;
                    else byte_d = byte_q + 7'd1;
                end
            end
            S_TRAILER: begin
                if (!afull_sel) begin
                    emit      = 1'b1;
                    emit_ctrl = 1'b1;
                    gap_d     = '0;
                    state_d   = S_GAP;
                end
            end
            S_GAP: begin
                clear = 1'b1;
                if (gap_q == 8'(GAP_CYCLES - 1)) begin
                    state_d      = S_IDLE;
                    desc_ready_d = 1'b1;
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            S_INIT: begin
                if ((&unit_in_ready) && !(|unit_in_afull)) begin
                    emit_all  = 1'b1;
                    emit_ctrl = 1'b1;
                    emit_byte = {init_data_q, 3'b001};
                    gap_d     = '0;
                    state_d   = S_GAP;
                end else begin
                    clear = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= S_IDLE;
            rr_q         <= '0;
            sel_q        <= '0;
            byte_q       <= '0;
            gap_q        <= '0;
            desc_ready_q <= 1'b0;
            len_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            sel_q        <= sel_d;
            byte_q       <= byte_d;
            gap_q        <= gap_d;
            desc_ready_q <= desc_ready_d;
            len_err_q    <= len_err_d;
        end
    end

    // A stalled lane keeps its data/ctrl and only drops wr_en; idle lanes are forced to zero.
    generate
        for (genvar gi = 0; gi < N_UNITS; gi++) begin : g_lane
            logic [7:0] data_q;
            logic       ctrl_q;
            logic       wr_q;
            logic       hit;
            assign hit = emit_all || (emit && (sel_q == UW'(gi)));
            always_ff @(posedge CLK) begin
                if (RST) begin
                    data_q <= 8'h00;
                    ctrl_q <= 1'b0;
                    wr_q   <= 1'b0;
                end else if (hit) begin
                    data_q <= emit_byte;
                    ctrl_q <= emit_ctrl;
                    wr_q   <= 1'b1;
                end else if (clear) begin
                    data_q <= 8'h00;
                    ctrl_q <= 1'b0;
                    wr_q   <= 1'b0;
                end else begin
                    wr_q   <= 1'b0;
                end
            end
            assign unit_in[gi*8 +: 8] = data_q;
            assign unit_in_ctrl[gi]   = ctrl_q;
            assign unit_in_wr_en[gi]  = wr_q;
        end
    endgenerate

    assign desc_ready = desc_ready_q;
    assign len_err    = len_err_q;

`ifdef UNIT_PKT_STATS_EN
    logic [31:0] pkt_count_q, stall_count_q;
    logic        pkt_ev, stall_ev;

    assign pkt_ev   = emit_all || (emit && state_q == S_TRAILER);
    assign stall_ev = (afull_sel && (state_q == S_HDR || state_q == S_BODY || state_q == S_TRAILER))
                   || (state_q == S_INIT && (&unit_in_ready) && (|unit_in_afull));

    always_ff @(posedge CLK) begin
        if (RST) begin
            pkt_count_q   <= '0;
            stall_count_q <= '0;
        end else begin
            if (pkt_ev && pkt_count_q != '1)     pkt_count_q   <= pkt_count_q + 32'd1;
            if (stall_ev && stall_count_q != '1) stall_count_q <= stall_count_q + 32'd1;
        end
    end

    assign pkt_count   = pkt_count_q;
    assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_unit_pkt_serializer.sv
// Scoreboard bench for unit_pkt_serializer (N_UNITS=4): expected words are queued per unit lane
// when a descriptor is issued, and a monitor thread pops and compares on every observed write.
module tb_unit_pkt_serializer;
    localparam int N   = 4;
    localparam int KML = 64;
    localparam int GAP = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             desc_valid = 1'b0;
    logic             desc_ready;
    logic             desc_init = 1'b0;
    logic [4:0]       desc_init_data = '0;
    logic [31:0]      desc_cnt = '0;
    logic [7:0]       desc_salt_len = '0;
    logic [127:0]     desc_salt = '0;
    logic [63:0]      desc_ids = '0;
    logic [7:0]       desc_key_len = '0;
    logic [KML*8-1:0] desc_key = '0;
    logic [8*N-1:0]   unit_in;
    logic [N-1:0]     unit_in_ctrl;
    logic [N-1:0]     unit_in_wr_en;
    logic [N-1:0]     unit_in_afull = '0;
    logic [N-1:0]     unit_in_ready = '1;
    logic             len_err;
`ifdef UNIT_PKT_STATS_EN
    logic [31:0]      pkt_count;
    logic [31:0]      stall_count;
`endif

    unit_pkt_serializer #(.N_UNITS(N), .KEY_MAX_LEN(KML), .GAP_CYCLES(GAP)) dut (
        .CLK(clk), .RST(rst),
        .desc_valid(desc_valid), .desc_ready(desc_ready),
        .desc_init(desc_init), .desc_init_data(desc_init_data),
        .desc_cnt(desc_cnt), .desc_salt_len(desc_salt_len), .desc_salt(desc_salt),
        .desc_ids(desc_ids), .desc_key_len(desc_key_len), .desc_key(desc_key),
        .unit_in(unit_in), .unit_in_ctrl(unit_in_ctrl), .unit_in_wr_en(unit_in_wr_en),
        .unit_in_afull(unit_in_afull), .unit_in_ready(unit_in_ready),
        .len_err(len_err)
`ifdef UNIT_PKT_STATS_EN
        , .pkt_count(pkt_count), .stall_count(stall_count)
`endif
    );

    always #5 clk = ~clk;

    // Entry = {kind, ctrl, data}; kind 0=header, 1=body, 2=trailer, 3=init word.
    logic [10:0] exp_q [N][$];
    int n_cmp = 0, n_mis = 0;
    int cyc = 0, wr_cnt = 0, pkt_wr = 0, lerr_cnt = 0;
    int hdr_cyc = 0, trl_cyc = 0, gap_idle = 0;
    int init_cyc [N];
    bit gap_armed = 0;
    logic [511:0] key_pat;

    task automatic chk(string name, int act, int req);
        n_cmp++;
        if (act != req) begin
            n_mis++;
            $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    function automatic int pending();
        int s = 0;
        for (int l = 0; l < N; l++) s += exp_q[l].size();
        return s;
    endfunction

    task automatic flush();
        for (int l = 0; l < N; l++) exp_q[l].delete();
        gap_armed = 0;
        pkt_wr    = 0;
    endtask

    task automatic monitor();
        logic [10:0] e;
        logic [8:0]  act;
        forever begin
            @(negedge clk);
            cyc++;
            if (len_err) lerr_cnt++;
            if (unit_in_wr_en != '0) begin
                if (gap_armed) begin
                    n_cmp++;
                    if (gap_idle < GAP) begin
                        n_mis++;
                        $display("FAIL gap_idle: got %0d idle cycles required >= %0d", gap_idle, GAP);
                    end
                    gap_armed = 0;
                end
            end else if (gap_armed) begin
                gap_idle++;
            end
            for (int l = 0; l < N; l++) begin
                if (1'(unit_in_wr_en >> l)) begin
                    wr_cnt++;
                    pkt_wr++;
                    act = {1'(unit_in_ctrl >> l), 8'(unit_in >> (8 * l))};
                    n_cmp++;
                    if (exp_q[l].size() == 0) begin
                        n_mis++;
                        $display("FAIL unexpected_write lane %0d: got %03h required no write", l, act);
                    end else begin
                        e = exp_q[l].pop_front();
                        if (act != e[8:0]) begin
                            n_mis++;
                            $display("FAIL stream lane %0d: got %03h required %03h", l, act, e[8:0]);
                        end
                        case (e[10:9])
                            2'd0: begin hdr_cyc = cyc; pkt_wr = 1; end
                            2'd2: begin trl_cyc = cyc; gap_armed = 1; gap_idle = 0; end
                            2'd3: begin init_cyc[l] = cyc; gap_armed = 1; gap_idle = 0; end
                            default: ;
                        endcase
                    end
                end
            end
        end
    endtask

    task automatic push(int lane, logic [1:0] kind, logic c, logic [7:0] d);
        exp_q[lane].push_back({kind, c, d});
    endtask

    // klen is the length as it should appear on the wire (already clamped by hand).
    task automatic push_pkt(int lane, logic [31:0] cnt, int slen, logic [127:0] salt,
                            logic [63:0] ids, int klen, logic [511:0] key);
        push(lane, 2'd0, 1'b1, 8'h00);
        for (int i = 0; i < 4; i++) push(lane, 2'd1, 1'b0, 8'(cnt >> (8 * i)));
        push(lane, 2'd1, 1'b0, 8'(slen));
        for (int i = 0; i < 3; i++) push(lane, 2'd1, 1'b0, 8'h00);
        for (int i = 0; i < 16; i++) push(lane, 2'd1, 1'b0, (i < slen) ? 8'(salt >> (8 * i)) : 8'h00);
        for (int i = 0; i < 8; i++) push(lane, 2'd1, 1'b0, 8'(ids >> (8 * i)));
        push(lane, 2'd1, 1'b0, 8'(klen));
        for (int i = 0; i < 7; i++) push(lane, 2'd1, 1'b0, 8'h00);
        for (int i = 0; i < (klen + 3) / 4 * 4; i++)
            push(lane, 2'd1, 1'b0, (i < klen) ? 8'(key >> (8 * i)) : 8'h00);
        push(lane, 2'd2, 1'b1, 8'h00);
    endtask

    task automatic send(bit init, logic [4:0] idata, logic [31:0] cnt, logic [7:0] slen,
                        logic [127:0] salt, logic [63:0] ids, logic [7:0] klen, logic [511:0] key);
        int t = 0;
        desc_init = init; desc_init_data = idata; desc_cnt = cnt; desc_salt_len = slen;
        desc_salt = salt; desc_ids = ids; desc_key_len = klen; desc_key = key;
        desc_valid = 1'b1;
        while (!desc_ready && t < 3000) begin
            @(negedge clk); #1;
            t++;
        end
        if (!desc_ready) begin
            n_cmp++; n_mis++;
            $display("FAIL desc_accept: got no desc_ready within %0d cycles required acceptance", t);
            desc_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        desc_valid = 1'b0;
        $display("desc init=%0d cnt=%08h salt_len=%0d key_len=%0d accepted at cycle %0d",
                 init, cnt, slen, klen, cyc);
    endtask

    task automatic drain(string name);
        int t = 0;
        while (pending() > 0 && t < 4000) begin
            @(negedge clk); #1;
            t++;
        end
        chk(name, pending(), 0);
        if (pending() > 0) flush();
    endtask

    task automatic wait_writes(int n);
        int t = 0;
        while (pkt_wr < n && t < 1000) begin
            @(negedge clk); #1;
            t++;
        end
        chk("wait_writes_reached", (pkt_wr >= n) ? n : pkt_wr, n);
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        flush();
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got simulation time limit required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int tgt_a [6];
        int tgt_b [6];
        int l0;
        tgt_a = '{1, 2, 3, 0, 1, 2};
        tgt_b = '{1, 3, 0, 1, 3, 0};
        key_pat = '0;
        for (int i = 0; i < 64; i++) key_pat = key_pat | (512'(8'(i * 3 + 1)) << (8 * i));

        fork
            monitor();
        join_none

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_desc_ready", int'(desc_ready), 0);
        chk("rst_wr_en", int'(unit_in_wr_en), 0);
        chk("rst_ctrl", int'(unit_in_ctrl), 0);
        chk("rst_unit_in", int'(unit_in), 0);
        chk("rst_len_err", int'(len_err), 0);
        #1 rst = 1'b0;

        // Basic data packet: rr starts at 0, so the scan picks unit 1
        push_pkt(1, 32'd10, 8, {64'h0, 64'h7373737373737373}, 64'h0f0f0f0f0f0f0f0f, 8,
                 {448'h0, 64'h3131313131313131});
        send(0, 5'd0, 32'd10, 8'd8, {64'h0, 64'h7373737373737373}, 64'h0f0f0f0f0f0f0f0f, 8'd8,
             {448'h0, 64'h3131313131313131});
        drain("t1_drain");
        chk("t1_span", trl_cyc - hdr_cyc + 1, 50);

        // afull held for 5 cycles in the middle of the salt
        pkt_wr = 0;
        push_pkt(2, 32'hdeadbeef, 16, 128'h00112233445566778899aabbccddeeff, 64'h8877665544332211, 48, key_pat);
        send(0, 5'd0, 32'hdeadbeef, 8'd16, 128'h00112233445566778899aabbccddeeff, 64'h8877665544332211, 8'd48, key_pat);
        wait_writes(12);
        unit_in_afull = '1;
        repeat (5) @(negedge clk);
        #1 unit_in_afull = '0;
        drain("t2_drain");
        chk("t2_span", trl_cyc - hdr_cyc + 1, 95);
`ifdef UNIT_PKT_STATS_EN
        chk("t2_stall_count", int'(stall_count), 5);
        chk("t2_pkt_count", int'(pkt_count), 2);
`endif

        // Round-robin, all ready
        do_reset();
        for (int i = 0; i < 6; i++) begin
            push_pkt(tgt_a[i], 32'(100 + i), 4, 128'h00000000_00000000_00000000_a1b2c3d4,
                     64'(i), 4, 512'(32'h55667788 + i));
            send(0, 5'd0, 32'(100 + i), 8'd4, 128'h00000000_00000000_00000000_a1b2c3d4,
                 64'(i), 8'd4, 512'(32'h55667788 + i));
        end
        drain("t3a_drain");

        // Round-robin skipping unit 2
        do_reset();
        unit_in_ready = 4'b1011;
        for (int i = 0; i < 6; i++) begin
            push_pkt(tgt_b[i], 32'(200 + i), 0, 128'h0, 64'(i * 7), 5, 512'(40'h0102030405 + i));
            send(0, 5'd0, 32'(200 + i), 8'd0, 128'h0, 64'(i * 7), 8'd5, 512'(40'h0102030405 + i));
        end
        drain("t3b_drain");
        unit_in_ready = '1;

        // Init broadcast held off by unit 3 afull
        unit_in_afull = 4'b1000;
        for (int l = 0; l < N; l++) push(l, 2'd3, 1'b1, 8'h09);
        l0 = wr_cnt;
        send(1, 5'd1, 32'd0, 8'd0, 128'h0, 64'h0, 8'd0, 512'h0);
        repeat (3) @(negedge clk);
        #1;
        chk("t4_no_write_while_afull", wr_cnt - l0, 0);
        unit_in_afull = '0;
        drain("t4_drain");
        chk("t4_same_cycle_l0_l3", init_cyc[3], init_cyc[0]);
        chk("t4_same_cycle_l1_l2", init_cyc[2], init_cyc[1]);

        // Length clamp and minimum-length packet
        l0 = lerr_cnt;
        push_pkt(1, 32'h11223344, 2, 128'hffee, 64'h1, 64, key_pat);
        send(0, 5'd0, 32'h11223344, 8'd2, 128'hffee, 64'h1, 8'd70, key_pat);
        drain("t5a_drain");
        chk("t5a_span", trl_cyc - hdr_cyc + 1, 106);
        chk("t5a_len_err_pulses", lerr_cnt - l0, 1);
        push_pkt(2, 32'h0, 16, 128'h0f0e0d0c0b0a09080706050403020100, 64'h2, 0, 512'h0);
        send(0, 5'd0, 32'h0, 8'd16, 128'h0f0e0d0c0b0a09080706050403020100, 64'h2, 8'd0, 512'h0);
        drain("t5b_drain");
        chk("t5b_span", trl_cyc - hdr_cyc + 1, 42);
        chk("t5b_len_err_pulses", lerr_cnt - l0, 1);

        // Reset in the middle of a packet
        pkt_wr = 0;
        push_pkt(3, 32'h77, 8, 128'h1, 64'h3, 8, key_pat);
        send(0, 5'd0, 32'h77, 8'd8, 128'h1, 64'h3, 8'd8, key_pat);
        wait_writes(20);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_wr_en_after_rst", int'(unit_in_wr_en), 0);
`ifdef UNIT_PKT_STATS_EN
        chk("t6_pkt_count_after_rst", int'(pkt_count), 0);
`endif
        #1;
        flush();
        rst = 1'b0;
        // rr is back at 0, so the scan restarts exactly as after power-up (unit 1 first)
        push_pkt(1, 32'h88, 8, 128'h2, 64'h4, 8, key_pat);
        send(0, 5'd0, 32'h88, 8'd8, 128'h2, 64'h4, 8'd8, key_pat);
        drain("t6_drain");
        chk("t6_span", trl_cyc - hdr_cyc + 1, 50);
`ifdef UNIT_PKT_STATS_EN
        chk("t6_pkt_count", int'(pkt_count), 1);
`endif

        repeat (10) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
